lut_ff_mux_array: RTL and testbench

//   Parametrised successor of the single LUT/FF/mux cell: NUM_CH independent channels.

---
 rtl/lut_ff_mux_pkg.sv | 15 +
 rtl/lut_ff_cell.sv | 35 +++
 rtl/lut_ff_mux_array.sv | 97 +++++++++
 tb/tb_lut_ff_mux_array.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_ff_mux_pkg.sv
// Shared types and sizing helpers for the LUT/FF/mux channel array.
package lut_ff_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Total number of INIT bits held by the array.
  function automatic int cfg_bits(input int num_ch, input int k);
    return num_ch * (2 ** k);
  endfunction

endpackage

// File: rtl/lut_ff_cell.sv
// One channel: K-input LUT read, clock-enabled flip-flop and a comb/registered output mux.
module lut_ff_cell
  import lut_ff_mux_pkg::*;
#(
  parameter int   K       = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**K-1:0]   init,
  input  logic [K-1:0]      in,
  input  logic              ce,
  input  logic              mux_sel,
  output logic              Q
);

  logic lut;
  logic ff_q;
  logic ff_d;

  assign lut = init[in];

  always_comb begin
    ff_d = ff_q;
    if (ce) ff_d = lut;
  end

  always_ff @(posedge clk) begin
    if (rst) ff_q <= RST_VAL;
    else     ff_q <= ff_d;
  end

  assign Q = mux_sel ? ff_q : lut;

endmodule

// File: rtl/lut_ff_mux_array.sv
// NUM_CH LUT/FF/mux channels with a serially loaded shadow table committed atomically,
// so the active logic keeps running on the old table for the whole load.
module lut_ff_mux_array
  import lut_ff_mux_pkg::*;
#(
  parameter int   NUM_CH  = 4,
  parameter int   K       = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*K-1:0]   in,
  input  logic [NUM_CH-1:0]     ce,
  input  logic [NUM_CH-1:0]     mux_sel,
  output logic [NUM_CH-1:0]     Q,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_busy,
  output logic                  cfg_done
);

  localparam int TBL      = 2 ** K;
  localparam int CFG_BITS = cfg_bits(NUM_CH, K);
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(CFG_BITS - 1);

  cfg_state_e          state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [CW-1:0]       count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      act_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      count_q  <= count_d;
    end
  end

  // cfg_start outranks cfg_valid in LOAD; COMMIT ignores both.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    act_d    = act_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          count_d = '0;
        end else if (cfg_valid) begin
          shadow_d = {shadow_q[CFG_BITS-2:0], cfg_bit};
          count_d  = count_q + CW'(1);
          if (count_q == LAST_IDX) state_d = COMMIT;
        end
      end
      COMMIT: begin
        act_d   = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_busy = (state_q == LOAD);
    cfg_done = (state_q == COMMIT);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    lut_ff_cell #(
      .K       (K),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .init    (act_q[gi*TBL +: TBL]),
      .in      (in[gi*K +: K]),
      .ce      (ce[gi]),
      .mux_sel (mux_sel[gi]),
      .Q       (Q[gi])
    );
  end

endmodule

// File: tb/tb_lut_ff_mux_array.sv
// Directed and random checks of the 2-channel, K=4 LUT/FF/mux array against a behavioural model.
module tb_lut_ff_mux_array;

  localparam int   NCH  = 2;
  localparam int   KK   = 4;
  localparam logic RVAL = 1'b0;

  typedef struct packed {
    logic [1:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_s = '0;
  logic [1:0] ce = '0;
  logic [1:0] mux_sel = '0;
  logic [1:0] Q;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_busy;
  logic       cfg_done;

  lut_ff_mux_array #(.NUM_CH(NCH), .K(KK), .RST_VAL(RVAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .ce        (ce),
    .mux_sel   (mux_sel),
    .Q         (Q),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  exp_t sb[$];

  // Inputs held across cycles by the stimulus tasks
  logic [7:0] g_in  = '0;
  logic [1:0] g_ce  = '0;
  logic [1:0] g_mux = '0;

  // Last sampled outputs and event counters
  logic [1:0] s_q;
  logic       s_busy, s_done;
  int         busy_n = 0;
  int         done_n = 0;

  // Behavioural model state (starts in its reset state)
  logic [31:0] m_act    = '0;
  logic [31:0] m_shadow = '0;
  int          m_cnt    = 0;
  int          m_st     = 0;
  logic [1:0]  m_ff     = {2{RVAL}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [1:0] lut;
    for (int c = 0; c < NCH; c++) lut[c] = m_act[c*16 + int'(in_s[c*4 +: 4])];
    for (int c = 0; c < NCH; c++) e.q[c] = mux_sel[c] ? m_ff[c] : lut[c];
    e.busy = (m_st == 1);
    e.done = (m_st == 2);
    return e;
  endfunction

  task automatic model_step();
    logic [1:0] lut;
    for (int c = 0; c < NCH; c++) lut[c] = m_act[c*16 + int'(in_s[c*4 +: 4])];
    if (rst) begin
      m_act = '0; m_shadow = '0; m_cnt = 0; m_st = 0; m_ff = {2{RVAL}};
    end else begin
      for (int c = 0; c < NCH; c++) if (ce[c]) m_ff[c] = lut[c];
      case (m_st)
        0: if (cfg_start) begin m_st = 1; m_cnt = 0; end
        1: begin
          if (cfg_start) m_cnt = 0;
          else if (cfg_valid) begin
            m_shadow = {m_shadow[30:0], cfg_bit};
            m_cnt++;
            if (m_cnt == 32) m_st = 2;
          end
        end
        default: begin m_act = m_shadow; m_st = 0; end
      endcase
    end
  endtask

  // One clock cycle: drive on negedge, score against the model, advance the model at posedge.
  task automatic cyc(input logic r, input logic s, input logic v, input logic b);
    exp_t e;
    @(negedge clk);
    rst = r; cfg_start = s; cfg_valid = v; cfg_bit = b;
    in_s = g_in; ce = g_ce; mux_sel = g_mux;
    sb.push_back(model_out());
    #1;
    s_q = Q; s_busy = cfg_busy; s_done = cfg_done;
    if (cfg_busy === 1'b1) busy_n++;
    if (cfg_done === 1'b1) done_n++;
    e = sb.pop_front();
    check("model", {28'd0, Q, cfg_busy, cfg_done}, {28'd0, e});
    @(posedge clk);
    model_step();
  endtask

  task automatic load(input logic [31:0] data, input bit gaps);
    for (int i = 31; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, data[i]);
    end
  endtask

  initial begin
    // 1. reset with arbitrary inputs
    g_in = 8'hA5; g_ce = 2'b11; g_mux = 2'b10;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_q", {30'd0, s_q}, 32'd0);
    check("rst_busy", {31'd0, s_busy}, 32'd0);
    check("rst_done", {31'd0, s_done}, 32'd0);

    // 2. load OR4 into ch1 and AND4 into ch0
    g_in = '0; g_ce = '0; g_mux = '0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    busy_n = 0; done_n = 0;
    load({16'hFFFE, 16'h8000}, 1'b0);
    check("load_busy_cycles", busy_n, 32);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("commit_done", {31'd0, s_done}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("done_pulses", done_n, 1);
    g_in = {4'h0, 4'hF};
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("lut_or0_and15", {30'd0, s_q}, 32'd1);
    g_in = {4'h2, 4'h4};
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("lut_or2_and4", {30'd0, s_q}, 32'd2);

    // 3. registered path latency and hold
    g_mux = 2'b11; g_ce = 2'b11; g_in = {4'h2, 4'hF};
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ff_not_before", {30'd0, s_q}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ff_one_cycle", {30'd0, s_q}, 32'd3);
    g_ce = 2'b00; g_in = 8'h00;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ff_hold", {30'd0, s_q}, 32'd3);

    // 4. zero-table load with gaps; old table stays active until commit
    g_mux = 2'b00; g_in = {4'h0, 4'hF};
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    load(32'h0, 1'b1);
    check("old_table_in_load", {30'd0, s_q}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("commit_q_old", {30'd0, s_q}, 32'd1);
    check("commit_done2", {31'd0, s_done}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("new_table_after", {30'd0, s_q}, 32'd0);

    // 5a. restart after 10 bits; restart cycle carries an ignored valid bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    done_n = 0;
    load({16'hFFFE, 16'h8000}, 1'b0);
    check("restart_no_early_done", done_n, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_done", {31'd0, s_done}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_table", {30'd0, s_q}, 32'd1);

    // 5b. reset aborts a load after 20 bits
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    done_n = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_busy", {31'd0, s_busy}, 32'd0);
    check("abort_q", {30'd0, s_q}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", done_n, 0);

    // 6. random traffic with interleaved loads, scored by the model every cycle
    for (int i = 0; i < 200; i++) begin
      g_in  = 8'($urandom);
      g_ce  = 2'($urandom);
      g_mux = 2'($urandom);
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
